// File: rtl/result_fifo_64bit.sv
// Show-ahead FIFO buffering {carry, sum} results from a pipelined adder.
// No upstream backpressure: pushes into a full FIFO are dropped and counted.
module result_fifo_64bit #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic [DATA_WIDTH:0]      i_result,
  input  logic                     i_ready,
  input  logic                     i_clr,
  output logic                     o_valid,
  output logic [DATA_WIDTH:0]      o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          valid_q, full_q, ovf_q;
  logic [7:0]    drop_q;
  logic          push, pop, drop;

  // A pop frees the slot the same-cycle push lands in, so full+pop still accepts.
  assign pop     = valid_q & i_ready;
  assign push    = i_en & (~full_q | pop);
  assign drop    = i_en & full_q & ~pop;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      full_q  <= (count_d == (AW+1)'(DEPTH));
      if (drop) begin
        ovf_q  <= 1'b1;
        drop_q <= i_clr ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
      end else if (i_clr) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= i_result;
  end

  assign o_valid    = valid_q;
  assign o_data     = mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = drop_q;
endmodule

// File: tb/tb_result_fifo_64bit.sv
// Directed and randomized checks of result_fifo_64bit against hand values and a queue model.
module tb_result_fifo_64bit;
  logic        clk = 1'b0;
  logic        rst, i_en, i_ready, i_clr;
  logic [64:0] i_result;
  logic        o_valid, o_full, o_overflow;
  logic [64:0] o_data;
  logic [3:0]  o_count;
  logic [7:0]  o_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [64:0] v [8];

  result_fifo_64bit #(.DATA_WIDTH(64), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_result(i_result), .i_ready(i_ready),
    .i_clr(i_clr), .o_valid(o_valid), .o_data(o_data), .o_count(o_count),
    .o_full(o_full), .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_en = 1'b0; i_ready = 1'b0; i_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_en = 1'b0; i_ready = 1'b0; i_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic fill();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      i_en = 1'b1; i_result = v[k];
      step();
    end
    i_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (o_valid !== 1'b0 || o_count !== 4'd0 || o_full !== 1'b0 || o_overflow !== 1'b0 || o_drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%b count=%0d full=%b ovf=%b drop=%0d, want all zero", o_valid, o_count, o_full, o_overflow, o_drop_cnt);
    end
  endtask

  task automatic test_single_push();
    do_reset();
    i_en = 1'b1; i_result = 65'h1_0000_0000_0000_0001;
    n_chk++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_bypass: valid=%b want 0", o_valid);
    end
    step();
    i_en = 1'b0;
    n_chk++;
    if (o_valid !== 1'b1 || o_data !== 65'h1_0000_0000_0000_0001 || o_count !== 4'd1) begin
      n_fail++;
      $display("FAIL single_push: valid=%b data=%h count=%0d, want 1 10000000000000001 1", o_valid, o_data, o_count);
    end
  endtask

  task automatic test_fill_drain();
    fill();
    n_chk++;
    if (o_full !== 1'b1 || o_count !== 4'd8 || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL fill: full=%b count=%0d valid=%b, want 1 8 1", o_full, o_count, o_valid);
    end
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (o_valid !== 1'b1 || o_data !== v[k]) begin
        n_fail++; $display("FAIL drain[%0d]: valid=%b data=%h, want 1 %h", k, o_valid, o_data, v[k]);
      end
      step();
    end
    i_ready = 1'b0;
    n_chk++;
    if (o_valid !== 1'b0 || o_count !== 4'd0 || o_full !== 1'b0) begin
      n_fail++; $display("FAIL drained: valid=%b count=%0d full=%b, want 0 0 0", o_valid, o_count, o_full);
    end
  endtask

  task automatic test_overflow();
    fill();
    for (int k = 0; k < 3; k++) begin
      i_en = 1'b1; i_result = 65'h0_DEAD_0000_0000_0000 + 65'(k);
      step();
    end
    i_en = 1'b0;
    n_chk++;
    if (o_overflow !== 1'b1 || o_drop_cnt !== 8'd3 || o_count !== 4'd8) begin
      n_fail++; $display("FAIL overflow: ovf=%b drop=%0d count=%0d, want 1 3 8", o_overflow, o_drop_cnt, o_count);
    end
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    n_chk++;
    if (o_overflow !== 1'b0 || o_drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL clr: ovf=%b drop=%0d, want 0 0", o_overflow, o_drop_cnt);
    end
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (o_data !== v[k]) begin
        n_fail++; $display("FAIL ovf_contents[%0d]: data=%h want %h", k, o_data, v[k]);
      end
      step();
    end
    i_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [64:0] nv;
    nv = 65'h1_CAFE_F00D_1234_5678;
    fill();
    i_en = 1'b1; i_ready = 1'b1; i_result = nv;
    step();
    i_en = 1'b0; i_ready = 1'b0;
    n_chk++;
    if (o_count !== 4'd8 || o_full !== 1'b1 || o_overflow !== 1'b0 || o_drop_cnt !== 8'd0 || o_data !== v[1]) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d full=%b ovf=%b drop=%0d data=%h, want 8 1 0 0 %h", o_count, o_full, o_overflow, o_drop_cnt, o_data, v[1]);
    end
    i_ready = 1'b1;
    for (int k = 1; k < 9; k++) begin
      n_chk++;
      if (o_data !== ((k == 8) ? nv : v[k])) begin
        n_fail++; $display("FAIL full_pp_order[%0d]: data=%h want %h", k, o_data, (k == 8) ? nv : v[k]);
      end
      step();
    end
    i_ready = 1'b0;
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    i_en = 1'b1; i_ready = 1'b1; i_result = 65'h0_1111_2222_3333_4444;
    step();
    i_en = 1'b0; i_ready = 1'b0;
    n_chk++;
    if (o_count !== 4'd1 || o_valid !== 1'b1 || o_data !== 65'h0_1111_2222_3333_4444) begin
      n_fail++; $display("FAIL empty_push_pop: count=%0d valid=%b data=%h, want 1 1 011112222333344 44", o_count, o_valid, o_data);
    end
  endtask

  task automatic test_clr_drop_sat();
    fill();
    i_en = 1'b1;
    step(); step();
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    n_chk++;
    if (o_overflow !== 1'b1 || o_drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL clr_vs_drop: ovf=%b drop=%0d, want 1 1", o_overflow, o_drop_cnt);
    end
    for (int k = 0; k < 260; k++) step();
    i_en = 1'b0;
    n_chk++;
    if (o_drop_cnt !== 8'd255 || o_overflow !== 1'b1) begin
      n_fail++; $display("FAIL drop_sat: drop=%0d ovf=%b, want 255 1", o_drop_cnt, o_overflow);
    end
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      i_en = 1'b1; i_result = v[k];
      step();
    end
    rst = 1'b1; i_en = 1'b1; i_ready = 1'b1; i_result = v[7];
    step();
    rst = 1'b0; i_en = 1'b0; i_ready = 1'b0;
    n_chk++;
    if (o_count !== 4'd0 || o_valid !== 1'b0 || o_overflow !== 1'b0 || o_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: count=%0d valid=%b ovf=%b full=%b, want 0 0 0 0", o_count, o_valid, o_overflow, o_full);
    end
    i_en = 1'b1; i_result = v[6];
    step();
    i_en = 1'b0;
    n_chk++;
    if (o_count !== 4'd1 || o_data !== v[6]) begin
      n_fail++; $display("FAIL after_reset_push: count=%0d data=%h, want 1 %h", o_count, o_data, v[6]);
    end
  endtask

  task automatic test_random();
    logic [64:0] q [$];
    logic        m_ovf;
    int          m_drop;
    logic        en, rdy, clr, mpop, mpush, mdrop, mfull;
    logic [64:0] d;
    do_reset();
    m_ovf = 1'b0; m_drop = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (((cyc / 500) % 2) == 0) begin
        en = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 3) == 0);
      end else begin
        en = ($urandom_range(0, 3) == 0); rdy = ($urandom_range(0, 3) != 0);
      end
      clr = ($urandom_range(0, 63) == 0);
      d = {1'($urandom), 32'($urandom), 32'($urandom)};
      i_en = en; i_ready = rdy; i_clr = clr; i_result = d;
      n_chk++;
      if (o_valid !== (q.size() != 0) || o_count !== 4'(q.size()) || o_full !== (q.size() == 8) ||
          o_overflow !== m_ovf || o_drop_cnt !== 8'(m_drop)) begin
        n_fail++;
        $display("FAIL rand_status@%0d: valid=%b count=%0d full=%b ovf=%b drop=%0d, want count=%0d ovf=%b drop=%0d",
                 cyc, o_valid, o_count, o_full, o_overflow, o_drop_cnt, q.size(), m_ovf, m_drop);
      end
      if (q.size() != 0) begin
        n_chk++;
        if (o_data !== q[0]) begin
          n_fail++; $display("FAIL rand_data@%0d: data=%h want %h", cyc, o_data, q[0]);
        end
      end
      mfull = (q.size() == 8);
      mpop  = rdy && (q.size() != 0);
      mpush = en && (!mfull || mpop);
      mdrop = en && mfull && !mpop;
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(d);
      if (mdrop) begin
        m_ovf = 1'b1;
        m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (clr) begin
        m_ovf = 1'b0; m_drop = 0;
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    i_result = '0;
    for (int k = 0; k < 8; k++) v[k] = {1'(k % 2), 64'hA5A5_0000_0000_0000 + 64'(k * 17)};
    test_reset();
    test_single_push();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_clr_drop_sat();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/result_fifo_64bit.md
RESULT_FIFO_64BIT -- requirements
Module: result_fifo_64bit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, adder operand width; entry width is DATA_WIDTH+1 (carry-out plus sum).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port i_en  input  1  result-valid strobe from the upstream pipelined adder; no backpressure upstream.
REQ-006 SHALL have port i_result  input  DATA_WIDTH+1  adder result {carry, sum}, sampled when i_en=1.
REQ-007 SHALL have port i_ready  input  1  downstream consumer accepts head entry this cycle.
REQ-008 SHALL have port i_clr  input  1  clears the sticky overflow flag and the drop counter.
REQ-009 SHALL have port o_valid  output  1  head entry available.
REQ-010 SHALL have port o_data  output  DATA_WIDTH+1  head entry (show-ahead).
REQ-011 SHALL have port o_count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port o_full  output  1  occupancy == DEPTH.
REQ-013 SHALL have port o_overflow  output  1  sticky: a result was dropped.
REQ-014 SHALL have port o_drop_cnt  output  8  number of dropped results, saturating at 255.

Function
REQ-015 Push: i_en=1 and (not full, or pop in the same cycle) SHALL write i_result at the write pointer and advance it.
REQ-016 Pop: o_valid=1 and i_ready=1 SHALL advance the read pointer; i_ready with o_valid=0 SHALL have no effect.
REQ-017 Entries SHALL be stored and delivered in arrival order, bit-exact, carry bit included.
REQ-018 Latency: an entry pushed into an empty FIFO at edge N SHALL appear on o_valid/o_data after edge N (visible in cycle N+1); there is no same-cycle bypass.
REQ-019 o_data SHALL equal the head entry whenever o_valid=1; it is don't-care when o_valid=0.
REQ-020 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by the occupancy counter or an extra pointer bit.
REQ-021 Simultaneous push and pop when 0<count<DEPTH: count SHALL be unchanged and both pointers SHALL advance.
REQ-022 Simultaneous push and pop when full: the push SHALL be accepted, count SHALL stay DEPTH, and no overflow SHALL be flagged.
REQ-023 Simultaneous push and pop when empty: only the push SHALL take effect (no bypass), so count becomes 1.
REQ-024 Push when full without a pop SHALL drop the input: storage and pointers unchanged, o_overflow set to 1, o_drop_cnt incremented (saturating).
REQ-025 o_overflow SHALL stay 1 until i_clr or rst; i_clr SHALL zero o_overflow and o_drop_cnt at the next edge.
REQ-026 If i_clr and a drop occur in the same cycle, the drop SHALL win: o_overflow=1 and o_drop_cnt=1.
REQ-027 o_count, o_full and o_valid SHALL be registered and consistent with each other every cycle (o_valid = count!=0).

Reset
REQ-028 While rst=1 at a clock edge, the next state SHALL be: pointers 0, o_count 0, o_valid 0, o_full 0, o_overflow 0, o_drop_cnt 0.
REQ-029 rst SHALL override i_en, i_ready and i_clr in the same cycle; stored contents are discarded and storage data need not be reset.
REQ-030 Reset asserted mid-stream SHALL discard all pending entries; the first push after rst deasserts SHALL behave as a push into an empty FIFO.

Verification
REQ-031 Single push 65'h1_0000_0000_0000_0001 into an empty FIFO with i_ready=0 -> next cycle o_valid=1, o_data=65'h1_0000_0000_0000_0001, o_count=1.
REQ-032 Push 8 distinct values back-to-back with i_ready=0 -> o_full=1, o_count=8; then i_ready=1 for 8 cycles -> values come out in order, then o_valid=0.
REQ-033 FIFO full, i_en=1 for 3 cycles, i_ready=0 -> o_overflow=1, o_drop_cnt=3, contents unchanged; then i_clr=1 -> both clear.
REQ-034 FIFO full, i_en=1 and i_ready=1 in the same cycle -> head pops, new value is appended, o_count stays 8, o_overflow=0.
REQ-035 FIFO holds 5 entries and rst=1 for one cycle while i_en=1 -> o_count=0, o_valid=0, o_overflow=0.
REQ-036 Random i_en/i_ready for 10k cycles against a reference queue model -> no mismatch, and drops occur only when full without a pop.
